// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and host handshake bundle for the UART receiver.
//   rx        : serial line from the pad, idle high
//   rd        : consumer acknowledge
//   data_out  : last good received word, bit 0 = first data bit on the line
//   valid     : data_out holds an unread word
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : sticky, an unread word was overwritten
//   busy      : receiver is inside a frame (any state other than idle)
// master = line/host side driving rx and rd, slave = the receiver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 rd;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx, rd,
        input  data_out, valid, frame_err, overrun, busy
    );

    modport slave (
        input  rx, rd,
        output data_out, valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver.
// Frame: start bit, DATA_BITS data bits LSB first, one stop bit.
// The line is sampled at mid-bit by a clock-count baud timer.
// Ports:
//   clk  : system clock, rising edge
//   RSTn : synchronous active-low reset
//   bus  : uart_rx_if slave (rx, rd in; data_out, valid, frame_err,
//          overrun, busy out)
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic      clk,
    input  logic      RSTn,
    uart_rx_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;
    logic                 w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_sync      <= 2'b11;   // preset to idle level so reset is not seen as a start
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], bus.rx};
            r_frame_err <= 1'b0;

            if (bus.rd && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            // start bit vanished before mid-bit: treat as glitch
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (r_idx == IW'(i)) r_shreg[i] <= w_rx_s;
                        end
                        r_cnt <= '0;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST_IX) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data    <= r_shreg;
                            r_valid   <= 1'b1;
                            // a same-cycle rd consumes the old word, so no overrun
                            r_overrun <= !bus.rd && (r_valid || r_overrun);
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    // wait out a held-low line so it cannot look like a new start
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int C = 16;
    localparam int D = 8;
    localparam int H = C / 2;
    // rising edges from driving the start bit to the edge that delivers the word:
    // 2 synchronizer edges + 1 idle detect edge + half bit + (D+1) full bits
    localparam int STOP_EDGE = 3 + H + (D + 1) * C;

    logic clk  = 1'b0;
    logic RSTn = 1'b0;

    uart_rx_if #(.DATA_BITS(D)) bus ();

    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fe_pulses = 0;
    int   vrise = -1;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.frame_err === 1'b1) fe_pulses <= fe_pulses + 1;
        if (bus.valid === 1'b1 && prev_v !== 1'b1) vrise <= cyc + 1;
        prev_v <= bus.valid;
    end

    // reference model of the host-visible state
    logic         m_valid = 1'b0;
    logic         m_ovr   = 1'b0;
    logic [D-1:0] m_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".valid"},   32'(bus.valid),    32'(m_valid));
        check({tag, ".data"},    32'(bus.data_out), 32'(m_data));
        check({tag, ".overrun"}, 32'(bus.overrun),  32'(m_ovr));
    endtask

    task automatic send_frame(input logic [D-1:0] data, input logic stop_bit,
                              input logic rd_at_stop);
        logic [D+1:0] line;
        int fe0;
        line = {stop_bit, data, 1'b0};
        fe0  = fe_pulses;
        for (int k = 0; k < (D + 2) * C; k++) begin
            bus.rx = line[k / C];
            bus.rd = rd_at_stop && (k == STOP_EDGE - 1);
            tick();
        end
        bus.rd = 1'b0;
        if (stop_bit) begin
            m_ovr   = !rd_at_stop && m_valid;
            m_valid = 1'b1;
            m_data  = data;
        end else if (rd_at_stop) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check("frame_err_count", 32'(fe_pulses - fe0), stop_bit ? 32'd0 : 32'd1);
    endtask

    task automatic do_rd();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    initial begin
        int c0;
        int fe0;
        logic [D-1:0] rdat;
        logic rstop, rrd;

        bus.rx = 1'b1;
        bus.rd = 1'b0;

        // reset with a toggling line
        RSTn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rx = i[0];
            tick();
        end
        check("rst.valid",     32'(bus.valid),     32'd0);
        check("rst.data",      32'(bus.data_out),  32'd0);
        check("rst.frame_err", 32'(bus.frame_err), 32'd0);
        check("rst.overrun",   32'(bus.overrun),   32'd0);
        check("rst.busy",      32'(bus.busy),      32'd0);
        bus.rx = 1'b1;
        RSTn   = 1'b1;
        repeat (4) tick();
        check("post_rst.busy", 32'(bus.busy), 32'd0);

        // single byte with latency check
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5.latency", 32'(vrise - c0), 32'(STOP_EDGE));
        check_outs("a5");
        check("a5.busy", 32'(bus.busy), 32'd0);
        do_rd();
        check_outs("a5_rd");

        // short glitch is rejected
        fe0 = fe_pulses;
        bus.rx = 1'b0;
        repeat (4) tick();
        bus.rx = 1'b1;
        repeat (2) tick();
        check("glitch.busy_hi", 32'(bus.busy), 32'd1);
        repeat (8) tick();
        check("glitch.busy_lo", 32'(bus.busy), 32'd0);
        check("glitch.fe", 32'(fe_pulses - fe0), 32'd0);
        check_outs("glitch");

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0);
        fe0 = fe_pulses;
        repeat (40) tick();
        check("ferr.busy_held", 32'(bus.busy), 32'd1);
        check("ferr.no_extra_fe", 32'(fe_pulses - fe0), 32'd0);
        check_outs("ferr");
        bus.rx = 1'b1;
        repeat (4) tick();
        check("ferr.busy_rel", 32'(bus.busy), 32'd0);
        send_frame(8'h01, 1'b1, 1'b0);
        check_outs("after_ferr");
        do_rd();

        // overrun
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_outs("ovr");
        do_rd();
        check_outs("ovr_rd");

        // rd coinciding with a good completion, then with a framing error
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1);
        check_outs("rd_good");
        send_frame(8'h55, 1'b0, 1'b1);
        check_outs("rd_ferr");
        bus.rx = 1'b1;
        repeat (4) tick();
        check("rd_ferr.busy", 32'(bus.busy), 32'd0);

        // reset in the middle of data bit 4 of 0xFF
        send_frame(8'h77, 1'b1, 1'b0);
        for (int k = 0; k < C + 4 * C + H; k++) begin
            bus.rx = (k < C) ? 1'b0 : 1'b1;
            tick();
        end
        RSTn = 1'b0;
        repeat (2) tick();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = '0;
        RSTn   = 1'b1;
        bus.rx = 1'b1;
        repeat (4) tick();
        check_outs("midrst");
        send_frame(8'h5A, 1'b1, 1'b0);
        check_outs("midrst_5a");
        do_rd();

        // randomized frames
        for (int n = 0; n < 10; n++) begin
            rdat  = D'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rrd   = $urandom_range(0, 1) == 1;
            send_frame(rdat, rstop, rrd);
            if (!rstop) begin
                bus.rx = 1'b1;
                repeat (4) tick();
            end
            check_outs("rand");
            if ($urandom_range(0, 2) == 0) do_rd();
        end
        check("rand.busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver, fixed 8N1-style framing: start bit, DATA_BITS data bits LSB first, one stop bit.
- Samples the asynchronous rx line at mid-bit using a clock-count baud timer.
- Presents each received byte on a parallel output held until the consumer acknowledges it.
- Receive-side counterpart of the team's transmit datapath; sits between the pad and the host-side register interface.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Even, >= 4.
- DATA_BITS, 8: data bits per frame, range 5..9.

Ports:
- clk  input  1  system clock, rising edge.
- RSTn  input  1  synchronous active-low reset, sampled on rising clk.
- rx  input  1  asynchronous serial line, idle high.
- rd  input  1  consumer acknowledge; clears valid and overrun.
- data_out  output  DATA_BITS  last good received word, bit 0 = first data bit on the line.
- valid  output  1  data_out holds an unread word.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; a new word overwrote an unread one.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RSTn=0 at a clk edge):
  - data_out=0, valid=0, frame_err=0, overrun=0, busy=0.
  - FSM goes to IDLE; bit counter and index cleared.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Synchronizer: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only, which adds 2 cycles of latency.
- FSM states and transitions:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1, sample rx_s:
    - rx_s==0: go to DATA with cnt=0, idx=0.
    - rx_s==1: false start (glitch); go back to IDLE. No flag is raised.
  - DATA: at cnt==CLKS_PER_BIT-1:
    - Shift rx_s into bit position idx of the shift register; set cnt=0, idx=idx+1.
    - After the bit with idx==DATA_BITS-1, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: load data_out from the shift register, set valid=1, go to IDLE.
    - rx_s==0: pulse frame_err for one cycle. data_out and valid are unchanged. Go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. Prevents a held-low line from re-triggering START.
- Timing:
  - From the first cycle rx_s==0 in IDLE to the stop sample: CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles.
  - valid (or frame_err) asserts on the next edge.
  - Back-to-back frames are accepted: IDLE can detect a new start on the cycle after it is re-entered.
- Handshake:
  - rd=1 with valid=1: valid=0 and overrun=0 on the next edge.
  - rd=1 with valid=0: no effect.
- Overrun:
  - A good frame completes while valid==1 and rd==0: data_out is overwritten, valid stays 1, overrun=1.
  - overrun stays set until rd.
- Simultaneous rd and good-frame completion:
  - New word loads and valid stays 1.
  - overrun is cleared (the old word was read), not set.
- Simultaneous rd and frame_err: valid is cleared; frame_err pulses; data_out is unchanged.

Test Plan:
- Reset: hold RSTn=0 for 3 cycles with rx toggling -> all outputs 0, busy=0. After release with rx=1 -> busy stays 0.
- Single byte, CLKS_PER_BIT=16: send 0xA5 (bit sequence 1,0,1,0,0,1,0,1 after start) with stop=1 -> valid rises exactly 8+9*16=152 cycles after the first rx_s low, data_out=0xA5, frame_err never pulses. Then rd=1 -> valid=0 on the next cycle.
- Glitch: drive rx low for 4 cycles, then high -> returns to IDLE, busy drops after ~8 cycles, valid=0, frame_err=0.
- Framing error: send 0x3C with stop bit=0 and rx held low for 40 more cycles -> frame_err one-cycle pulse, valid=0, busy=1 until rx returns high. Then a good 0x01 frame -> data_out=0x01, valid=1.
- Overrun: send 0x11 and 0x22 back-to-back with no rd -> data_out=0x22, valid=1, overrun=1. Then rd -> valid=0, overrun=0.
- Reset mid-frame: assert RSTn=0 during data bit 4 of 0xFF, then send 0x5A -> 0xFF is never delivered, data_out=0x5A, valid=1, overrun=0.
